// File: rtl/tt_ctrl_pkg.sv
// Shared types for the mux control-pad sequencer: FSM states, pad bit order, timer sizing.
// No logic; latency and backpressure are defined by the modules that import this package.
// The ctrl bit order matches pads 38/39/40.
package tt_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DIS,
      RST,
      RGAP,
      INC_HI,
      INC_LO,
      DONE
   } seq_state_t;

   localparam int CTRL_ENA       = 0;
   localparam int CTRL_INC       = 1;
   localparam int CTRL_SEL_RST_N = 2;
   localparam int CTRL_W         = 3;

   // Width of a down-counter that must hold max(p,g)-1; never narrower than one bit.
   function automatic int tmr_width(input int p, input int g);
      int m;
      m = (p > g) ? p : g;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/tt_ctrl_timer.sv
// Loadable phase down-counter with a zero flag; it holds at zero until reloaded.
// The load value is visible on the next cycle, and zero is combinational from the count.
// It has no backpressure, and the owner reloads it on every phase change.
module tt_ctrl_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/tt_ctrl_sequencer.sv
// Replays the tt mux selection protocol (disable, sel_rst_n pulse, addr x sel_inc pulses, optional enable).
// Latency from acceptance to done is G+P+G+addr*(P+G)+1 cycles, and every output is registered.
// req_ready is high only in IDLE, and a request that arrives while busy is ignored and not queued.
module tt_ctrl_sequencer
   import tt_ctrl_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int PULSE_CYCLES = 2,
   parameter int GAP_CYCLES   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_ena,
   output logic              ctrl_ena,
   output logic              ctrl_sel_inc,
   output logic              ctrl_sel_rst_n,
   output logic              done,
   output logic [ADDR_W-1:0] sel_addr,
   output logic              sel_valid
);

   localparam int TW = tmr_width(PULSE_CYCLES, GAP_CYCLES);
   localparam logic [TW-1:0] P_LD = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] G_LD = TW'(GAP_CYCLES - 1);

   seq_state_t        state_q, state_d;
   logic              tmr_load;
   logic [TW-1:0]     tmr_val;
   logic              tmr_zero;
   logic [ADDR_W-1:0] inc_cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              ena_q;
   logic [CTRL_W-1:0] ctrl_q;
   logic              accept;

   assign accept = (state_q == IDLE) && req_valid && req_ready;

   tt_ctrl_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = G_LD;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = DIS;
               tmr_load = 1'b1;
               tmr_val  = G_LD;
            end
         end
         DIS: begin
            if (tmr_zero) begin
               state_d  = RST;
               tmr_load = 1'b1;
               tmr_val  = P_LD;
            end
         end
         RST: begin
            if (tmr_zero) begin
               state_d  = RGAP;
               tmr_load = 1'b1;
               tmr_val  = G_LD;
            end
         end
         RGAP: begin
            if (tmr_zero) begin
               if (inc_cnt_q == '0) begin
                  state_d = DONE;
               end else begin
                  state_d  = INC_HI;
                  tmr_load = 1'b1;
                  tmr_val  = P_LD;
               end
            end
         end
         INC_HI: begin
            if (tmr_zero) begin
               state_d  = INC_LO;
               tmr_load = 1'b1;
               tmr_val  = G_LD;
            end
         end
         INC_LO: begin
            // The counter is decremented here as well, so reaching one means this was the last pulse.
            if (tmr_zero) begin
               if (inc_cnt_q == ADDR_W'(1)) begin
                  state_d = DONE;
               end else begin
                  state_d  = INC_HI;
                  tmr_load = 1'b1;
                  tmr_val  = P_LD;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_cnt_q <= '0;
         addr_q    <= '0;
         ena_q     <= 1'b0;
      end else if (accept) begin
         inc_cnt_q <= req_addr;
         addr_q    <= req_addr;
         ena_q     <= req_ena;
      end else if (state_q == INC_LO && tmr_zero) begin
         inc_cnt_q <= inc_cnt_q - 1'b1;
      end
   end

   // Pad outputs follow the current phase one cycle later; any pad not touched by a phase keeps its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         req_ready <= 1'b0;
         done      <= 1'b0;
         sel_addr  <= '0;
         sel_valid <= 1'b0;
      end else begin
         done      <= 1'b0;
         req_ready <= (state_q == IDLE) && !accept;
         case (state_q)
            DIS: begin
               ctrl_q[CTRL_ENA] <= 1'b0;
               sel_valid        <= 1'b0;
            end
            RST:    ctrl_q[CTRL_SEL_RST_N] <= 1'b0;
            RGAP:   ctrl_q[CTRL_SEL_RST_N] <= 1'b1;
            INC_HI: ctrl_q[CTRL_INC]       <= 1'b1;
            INC_LO: ctrl_q[CTRL_INC]       <= 1'b0;
            DONE: begin
               done             <= 1'b1;
               ctrl_q[CTRL_ENA] <= ena_q;
               sel_addr         <= addr_q;
               sel_valid        <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign ctrl_ena       = ctrl_q[CTRL_ENA];
   assign ctrl_sel_inc   = ctrl_q[CTRL_INC];
   assign ctrl_sel_rst_n = ctrl_q[CTRL_SEL_RST_N];

endmodule

// File: tb/tb_tt_ctrl_sequencer.sv
// Directed bench for tt_ctrl_sequencer: one P=2/G=1 instance and one P=4/G=3 instance.
// Outputs are sampled on the falling edge, and inputs are driven on the falling edge.
module tb_tt_ctrl_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       a_valid, a_ready, a_req_ena, a_ena, a_inc, a_srn, a_done, a_sv;
   logic [9:0] a_addr, a_sel;
   logic       b_valid, b_ready, b_req_ena, b_ena, b_inc, b_srn, b_done, b_sv;
   logic [9:0] b_addr, b_sel;

   tt_ctrl_sequencer #(.ADDR_W(10), .PULSE_CYCLES(2), .GAP_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
      .req_addr(a_addr), .req_ena(a_req_ena), .ctrl_ena(a_ena), .ctrl_sel_inc(a_inc),
      .ctrl_sel_rst_n(a_srn), .done(a_done), .sel_addr(a_sel), .sel_valid(a_sv)
   );

   tt_ctrl_sequencer #(.ADDR_W(10), .PULSE_CYCLES(4), .GAP_CYCLES(3)) u_dut_big (
      .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
      .req_addr(b_addr), .req_ena(b_req_ena), .ctrl_ena(b_ena), .ctrl_sel_inc(b_inc),
      .ctrl_sel_rst_n(b_srn), .done(b_done), .sel_addr(b_sel), .sel_valid(b_sv)
   );

   int n_chk = 0;
   int n_err = 0;
   int viol  = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // sel_inc must never be high while the selection is held in reset.
   always @(negedge clk) begin
      if (rst_n) begin
         if (a_inc && !a_srn) viol++;
         if (b_inc && !b_srn) viol++;
      end
   end

   // Drives a request on a falling edge and returns on the falling edge after the accepting rising edge (cycle 0).
   task automatic send_a(input logic [9:0] addr, input logic ena, output int waited);
      waited    = 0;
      a_valid   = 1'b1;
      a_addr    = addr;
      a_req_ena = ena;
      while (!a_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!a_ready) chk("send_a_timeout", a_ready, 1);
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
   endtask

   task automatic run_a(input int ncyc, output int pulses, output int done_at,
                        output int done_cnt, output logic [9:0] sa, output logic se);
      logic prev;
      pulses = 0; done_at = 0; done_cnt = 0; sa = '0; se = 1'b0;
      prev = a_inc;
      for (int n = 1; n <= ncyc; n++) begin
         @(negedge clk);
         if (a_inc && !prev) pulses++;
         prev = a_inc;
         if (a_done) begin
            done_cnt++;
            if (done_at == 0) begin
               done_at = n;
               sa      = a_sel;
               se      = a_ena;
            end
         end
      end
   endtask

   int         w, p, d, dc;
   logic [9:0] sa;
   logic       se;
   logic [15:1] v_inc, v_srn, v_done, v_ena, v_sv;
   logic [15:1] e_inc, e_srn, e_done, e_ena, e_sv;

   initial begin
      rst_n = 1'b0;
      a_valid = 1'b0; a_addr = '0; a_req_ena = 1'b0;
      b_valid = 1'b0; b_addr = '0; b_req_ena = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_ena", a_ena, 0);
      chk("rst_inc", a_inc, 0);
      chk("rst_srn", a_srn, 0);
      chk("rst_ready", a_ready, 0);
      chk("rst_done", a_done, 0);
      chk("rst_sv", a_sv, 0);
      chk("rst_sel", a_sel, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_ready", a_ready, 1);
      chk("rel_srn", a_srn, 0);
      chk("rel_ena", a_ena, 0);
      chk("rel_inc", a_inc, 0);

      // addr=0, ena=1: done at cycle 5, ready again at cycle 6
      send_a(10'd0, 1'b1, w);
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         case (n)
            1: begin chk("a0_ena@1", a_ena, 0); chk("a0_srn@1", a_srn, 0); end
            2: chk("a0_srn@2", a_srn, 0);
            3: begin chk("a0_srn@3", a_srn, 0); chk("a0_ready@3", a_ready, 0); end
            4: begin chk("a0_srn@4", a_srn, 1); chk("a0_done@4", a_done, 0); end
            5: begin
               chk("a0_done@5", a_done, 1);
               chk("a0_ena@5", a_ena, 1);
               chk("a0_sel@5", a_sel, 0);
               chk("a0_sv@5", a_sv, 1);
               chk("a0_ready@5", a_ready, 0);
            end
            default: begin chk("a0_ready@6", a_ready, 1); chk("a0_done@6", a_done, 0); end
         endcase
      end

      // addr=3, ena=0: waveform captured for cycles 1..15
      send_a(10'd3, 1'b0, w);
      for (int n = 1; n <= 15; n++) begin
         @(negedge clk);
         v_inc[n] = a_inc; v_srn[n] = a_srn; v_done[n] = a_done;
         v_ena[n] = a_ena; v_sv[n] = a_sv;
      end
      e_inc  = 15'b000110110110000;
      e_srn  = 15'b111111111111001;
      e_done = 15'b010000000000000;
      e_ena  = 15'b000000000000000;
      e_sv   = 15'b110000000000000;
      chk("a3_inc_wave", 32'(v_inc), 32'(e_inc));
      chk("a3_srn_wave", 32'(v_srn), 32'(e_srn));
      chk("a3_done_wave", 32'(v_done), 32'(e_done));
      chk("a3_ena_wave", 32'(v_ena), 32'(e_ena));
      chk("a3_sv_wave", 32'(v_sv), 32'(e_sv));
      chk("a3_sel", a_sel, 3);
      chk("a3_ready@15", a_ready, 1);

      // A request held while busy is ignored; the next acceptance happens only after DONE
      send_a(10'd1, 1'b1, w);
      a_valid = 1'b1; a_addr = 10'd2; a_req_ena = 1'b0;
      run_a(8, p, d, dc, sa, se);
      chk("busy_pulses", p, 1);
      chk("busy_done_at", d, 8);
      chk("busy_done_cnt", dc, 1);
      chk("busy_sel", sa, 1);
      chk("busy_ena", se, 1);
      send_a(10'd2, 1'b0, w);
      chk("busy_accept_wait", w, 1);
      run_a(12, p, d, dc, sa, se);
      chk("second_pulses", p, 2);
      chk("second_done_at", d, 11);
      chk("second_done_cnt", dc, 1);
      chk("second_sel", sa, 2);
      chk("second_ena", se, 0);

      // Reset dropped in the first INC_HI of addr=5
      send_a(10'd5, 1'b1, w);
      repeat (5) @(negedge clk);
      chk("mid_inc_hi", a_inc, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_inc", a_inc, 0);
      chk("mid_srn", a_srn, 0);
      chk("mid_ena", a_ena, 0);
      chk("mid_done", a_done, 0);
      chk("mid_sv", a_sv, 0);
      chk("mid_sel", a_sel, 0);
      chk("mid_ready", a_ready, 0);
      dc = 0;
      repeat (3) begin
         @(negedge clk);
         if (a_done) dc++;
      end
      chk("mid_no_done", dc, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rel_ready", a_ready, 1);
      send_a(10'd2, 1'b0, w);
      run_a(12, p, d, dc, sa, se);
      chk("after_pulses", p, 2);
      chk("after_done_at", d, 11);
      chk("after_done_cnt", dc, 1);
      chk("after_sel", sa, 2);

      // P=4, G=3, addr=1023
      b_valid = 1'b1; b_addr = 10'd1023; b_req_ena = 1'b1;
      w = 0;
      while (!b_ready && w < 20) begin
         @(negedge clk);
         w++;
      end
      if (!b_ready) chk("send_b_timeout", b_ready, 1);
      @(posedge clk);
      @(negedge clk);
      b_valid = 1'b0;
      begin
         logic prev;
         p = 0; d = 0; dc = 0; sa = '0; se = 1'b0;
         prev = b_inc;
         for (int n = 1; n <= 7180; n++) begin
            @(negedge clk);
            if (b_inc && !prev) p++;
            prev = b_inc;
            if (b_done) begin
               dc++;
               if (d == 0) begin d = n; sa = b_sel; se = b_ena; end
            end
         end
      end
      chk("big_pulses", p, 1023);
      chk("big_done_at", d, 7172);
      chk("big_done_cnt", dc, 1);
      chk("big_sel", sa, 1023);
      chk("big_ena", se, 1);
      chk("big_srn_end", b_srn, 1);
      chk("big_ready_end", b_ready, 1);

      chk("inc_during_sel_rst", viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
